// File: rtl/sp_ram_march_bist.sv
// sp_ram_march_bist: March C- self-test initiator for a single-port RAM.
//
// Runs six march elements over every address using background word BG_PATTERN
// and its inverse:
//   M0 up w(B), M1 up r(B)w(~B), M2 up r(~B)w(B),
//   M3 down r(B)w(~B), M4 down r(~B)w(B), M5 down r(B).
// It reports pass/fail, a saturating mismatch count and the first failing
// address, expected word and observed word.
//
// Optional build macro SP_RAM_BIST_STOP_ON_FAIL_EN: when defined, the run ends
// at the first mismatch without any further RAM access.
//
// Ports:
//   clk, rst_n          clock shared with the RAM; synchronous active-low reset
//   start               one-cycle run request, ignored while busy
//   busy, done, pass    run status; done/pass are sticky until the next start
//   err_cnt             mismatch count, saturating at 255
//   fail_addr/expect/got  details of the first mismatch
//   ram_data/addr/we    RAM drive; ram_q is the RAM read data
module sp_ram_march_bist #(
  parameter int unsigned           DATA_WIDTH   = 8,
  parameter int unsigned           ADDR_WIDTH   = 4,
  parameter int unsigned           READ_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] BG_PATTERN   = 8'h55
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [7:0]            err_cnt,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_expect,
  output logic [DATA_WIDTH-1:0] fail_got,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  localparam logic [7:0] LatLast  = 8'(READ_LATENCY - 1);
  localparam logic [2:0] LastElem = 3'd5;

  typedef enum logic [2:0] {StIdle, StRd, StCmp, StWr, StDone} state_e;

  state_e                state_q, state_d;
  logic [2:0]            elem_q, elem_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            lat_q, lat_d;
  logic                  busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [7:0]            err_q, err_d;
  logic [ADDR_WIDTH-1:0] faddr_q, faddr_d;
  logic [DATA_WIDTH-1:0] fexp_q, fexp_d, fgot_q, fgot_d;

  // Element decode
  logic                  elem_down, elem_has_wr, last_addr, mismatch, stop, adv;
  logic [DATA_WIDTH-1:0] rd_word, wr_word;

  always_comb begin
    elem_down   = (elem_q >= 3'd3);
    elem_has_wr = (elem_q != LastElem);
    rd_word     = (elem_q == 3'd2 || elem_q == 3'd4) ? ~BG_PATTERN : BG_PATTERN;
    wr_word     = (elem_q == 3'd1 || elem_q == 3'd3) ? ~BG_PATTERN : BG_PATTERN;
    last_addr   = elem_down ? (addr_q == '0) : (addr_q == '1);
    mismatch    = (ram_q != rd_word);
  end

  always_comb begin
    state_d = state_q;
    elem_d  = elem_q;
    addr_d  = addr_q;
    lat_d   = lat_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    faddr_d = faddr_q;
    fexp_d  = fexp_q;
    fgot_d  = fgot_q;
    adv     = 1'b0;
    stop    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StWr;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          err_d   = '0;
          faddr_d = '0;
          fexp_d  = '0;
          fgot_d  = '0;
          elem_d  = '0;
          addr_d  = '0;
          lat_d   = '0;
        end
      end
      StRd: begin
        if (lat_q == LatLast) begin
          state_d = StCmp;
          lat_d   = '0;
        end else begin
          lat_d = lat_q + 8'd1;
        end
      end
      StCmp: begin
        if (mismatch) begin
          if (err_q != 8'hFF) err_d = err_q + 8'd1;
          if (err_q == '0) begin
            faddr_d = addr_q;
            fexp_d  = rd_word;
            fgot_d  = ram_q;
          end
        end
`ifdef SP_RAM_BIST_STOP_ON_FAIL_EN
        stop = mismatch;
`endif
        if (stop) begin
          state_d = StDone;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = 1'b0;
        end else if (elem_has_wr) begin
          state_d = StWr;
        end else begin
          adv = 1'b1;
        end
      end
      StWr:    adv = 1'b1;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (adv) begin
      if (!last_addr) begin
        addr_d  = elem_down ? addr_q - 1'b1 : addr_q + 1'b1;
        state_d = (elem_q == '0) ? StWr : StRd;
      end else if (elem_q == LastElem) begin
        state_d = StDone;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pass_d  = (err_d == '0);
      end else begin
        elem_d  = elem_q + 3'd1;
        // Elements M3..M5 run downward, so they start at the top address
        addr_d  = (elem_q >= 3'd2) ? '1 : '0;
        state_d = StRd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      elem_q  <= '0;
      addr_q  <= '0;
      lat_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      faddr_q <= '0;
      fexp_q  <= '0;
      fgot_q  <= '0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      addr_q  <= addr_d;
      lat_q   <= lat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      faddr_q <= faddr_d;
      fexp_q  <= fexp_d;
      fgot_q  <= fgot_d;
    end
  end

  always_comb begin
    busy        = busy_q;
    done        = done_q;
    pass        = pass_q;
    err_cnt     = err_q;
    fail_addr   = faddr_q;
    fail_expect = fexp_q;
    fail_got    = fgot_q;
    ram_we      = (state_q == StWr);
    ram_addr    = addr_q;
    ram_data    = ram_we ? wr_word : '0;
  end

endmodule

// File: tb/tb_sp_ram_march_bist.sv
module tb_sp_ram_march_bist;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // DUT 1: default parameters, RAM model with optional stuck-at fault
  logic       start1 = 1'b0;
  logic       busy1, done1, pass1, we1;
  logic [7:0] err1, fexp1, fgot1, data1, q1;
  logic [3:0] faddr1, addr1;
  logic       fault = 1'b0;
  logic [7:0] mem1 [16];

  sp_ram_march_bist dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(err1), .fail_addr(faddr1), .fail_expect(fexp1), .fail_got(fgot1),
    .ram_data(data1), .ram_addr(addr1), .ram_we(we1), .ram_q(q1)
  );

  // Bit0 of address 5 stuck at 0 when fault is set
  always @(posedge clk) begin
    if (we1) mem1[addr1] <= (fault && addr1 == 4'd5) ? (data1 & 8'hFE) : data1;
    q1 <= mem1[addr1];
  end

  // DUT 2: READ_LATENCY=2 with a two-stage q pipeline
  logic       start2 = 1'b0;
  logic       busy2, done2, pass2, we2;
  logic [7:0] err2, fexp2, fgot2, data2, q2a, q2b;
  logic [3:0] faddr2, addr2;
  logic [7:0] mem2 [16];

  sp_ram_march_bist #(.READ_LATENCY(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2), .pass(pass2),
    .err_cnt(err2), .fail_addr(faddr2), .fail_expect(fexp2), .fail_got(fgot2),
    .ram_data(data2), .ram_addr(addr2), .ram_we(we2), .ram_q(q2b)
  );

  always @(posedge clk) begin
    if (we2) mem2[addr2] <= data2;
    q2a <= mem2[addr2];
    q2b <= q2a;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Pulse start on dut1, then count busy cycles and write pulses until busy falls.
  // inject_at >= 0 re-pulses start while busy at that busy-cycle index.
  task automatic run1(input int inject_at, output int busy_cyc, output int we_cnt);
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    check("done_cleared_on_start", done1, 0);
    busy_cyc = 0;
    we_cnt   = 0;
    for (int i = 0; i < 2000; i++) begin
      if (!busy1) break;
      busy_cyc++;
      if (we1) we_cnt++;
      start1 = (i == inject_at);
      @(negedge clk);
    end
    start1 = 1'b0;
    check("run1_finished", busy1, 0);
  endtask

  int bc, wc;
  logic [3:0] m3_first, m5_last;

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_outputs", {busy1, done1, pass1, we1, err1, faddr1, fexp1, fgot1, data1, addr1},
          '0);
    rst_n = 1'b1;

    // 1: fault-free run
    run1(-1, bc, wc);
    check("t1_busy_cycles", bc, 240);
    check("t1_we_pulses", wc, 80);
    check("t1_done", done1, 1);
    check("t1_pass", pass1, 1);
    check("t1_err_cnt", err1, 0);

    // 2/3: stuck-at-0 on bit0 of address 5
    fault = 1'b1;
    run1(-1, bc, wc);
`ifdef SP_RAM_BIST_STOP_ON_FAIL_EN
    check("t3_busy_cycles", bc, 33);
    check("t3_we_pulses", wc, 21);
    check("t3_err_cnt", err1, 1);
`else
    check("t2_busy_cycles", bc, 240);
    check("t2_we_pulses", wc, 80);
    check("t2_err_cnt", err1, 3);
`endif
    check("t2_done", done1, 1);
    check("t2_pass", pass1, 0);
    check("t2_fail_addr", faddr1, 5);
    check("t2_fail_expect", fexp1, 8'h55);
    check("t2_fail_got", fgot1, 8'h54);
    repeat (3) @(negedge clk);
    check("t3_no_write_after_done", we1, 0);
    fault = 1'b0;

    // 4: start while busy is ignored; start after done clears done
    run1(50, bc, wc);
    check("t4_busy_cycles", bc, 240);
    check("t4_we_pulses", wc, 80);
    check("t4_pass", pass1, 1);
    check("t4_err_cnt", err1, 0);

    // 5: reset at busy cycle 100
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    for (int i = 0; i < 100; i++) @(negedge clk);
    check("t5_busy_before_reset", busy1, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_rst_status", {busy1, done1, pass1, err1}, '0);
    check("t5_rst_fail_regs", {faddr1, fexp1, fgot1}, '0);
    check("t5_rst_ram_drive", {we1, addr1, data1}, '0);
    rst_n = 1'b1;
    run1(-1, bc, wc);
    check("t5_rerun_busy_cycles", bc, 240);
    check("t5_rerun_pass", pass1, 1);

    // 6: READ_LATENCY=2
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    bc = 0;
    m3_first = 4'hx;
    m5_last  = 4'hx;
    for (int i = 0; i < 2000; i++) begin
      if (!busy2) break;
      if (i == 144) m3_first = addr2;
      if (i == 319) m5_last = addr2;
      bc++;
      @(negedge clk);
    end
    check("t6_busy_cycles", bc, 320);
    check("t6_first_m3_addr", m3_first, 15);
    check("t6_last_m5_addr", m5_last, 0);
    check("t6_done", done2, 1);
    check("t6_pass", pass2, 1);
    check("t6_err_cnt", err2, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sp_ram_march_bist.md
Name: sp_ram_march_bist

Overview:
- March-test initiator for the single-port RAM (sp_ram). It drives the RAM's data/addr/we inputs and checks its q output.
- Runs a 6-element March C- sequence over every address. It reports pass or fail, the first failing address and data, and an error count.
- Sits beside the RAM and shares its clk. Used for power-on self-test and for bring-up checks on post-route netlists.

Parameters:
- DATA_WIDTH, 8, RAM word width.
- ADDR_WIDTH, 4, RAM address width; N = 2**ADDR_WIDTH words.
- READ_LATENCY, 1, cycles from addr presented with we=0 to ram_q valid (>=1).
- BG_PATTERN, 8'h55, background word; the inverse word is ~BG_PATTERN.

Ports:
- clk  in  1  rising-edge clock, same as RAM clk.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle request to begin a run; ignored while busy.
- busy  out  1  high while a run is in progress.
- done  out  1  sticky high after a run ends; cleared by the next accepted start.
- pass  out  1  valid while done; 1 = zero mismatches.
- err_cnt  out  8  mismatch count, saturates at 255.
- fail_addr  out  ADDR_WIDTH  address of the first mismatch.
- fail_expect  out  DATA_WIDTH  expected word at the first mismatch.
- fail_got  out  DATA_WIDTH  ram_q value at the first mismatch.
- ram_data  out  DATA_WIDTH  to RAM data.
- ram_addr  out  ADDR_WIDTH  to RAM addr.
- ram_we  out  1  to RAM we.
- ram_q  in  DATA_WIDTH  from RAM q.

Behaviour:
- Reset (rst_n=0 at an edge): every output goes to 0, state goes to IDLE. Reset mid-run aborts the run; RAM contents are left as they are.
- March elements, with B = BG_PATTERN:
  - M0: up, w(B)
  - M1: up, r(B) then w(~B)
  - M2: up, r(~B) then w(B)
  - M3: down, r(B) then w(~B)
  - M4: down, r(~B) then w(B)
  - M5: down, r(B)
- Address order: "up" runs 0..N-1; "down" runs N-1..0.
- States: IDLE, RD, CMP, WR, DONE.
- IDLE:
  - ram_we=0.
  - On start=1: clears done, pass, err_cnt and the fail_* outputs; sets busy=1; loads element M0 at address 0; goes to WR.
- RD:
  - ram_addr = current address, ram_we=0, held for READ_LATENCY cycles.
  - Then goes to CMP.
- CMP:
  - Address is still held and ram_we=0.
  - At the closing edge, ram_q is compared to the expected word.
  - On a mismatch: err_cnt increments (saturating). If this is the first mismatch, fail_addr, fail_expect and fail_got are captured.
  - Goes to WR if the element has a write, otherwise advances.
- WR:
  - One cycle with ram_we=1, ram_addr = current address, ram_data = write word.
  - Then advances.
- Advance:
  - Moves to the next address in the current element's order.
  - At the end of an element, loads the next element's first address and enters RD, or WR for M0.
  - After the last address of M5, goes to DONE.
- DONE:
  - busy=0, done=1, pass=(err_cnt==0), ram_we=0.
  - Returns to IDLE on the same edge; done and pass stay sticky.
- Run length: N + 4*N*(READ_LATENCY+2) + N*(READ_LATENCY+1) operation cycles. With the defaults this is 240. busy falls on the edge after the last operation cycle.
- ram_data is don't-care when ram_we=0 but is driven to 0.
- Address wrap: the counter never wraps within an element; direction is applied per element.
- start and reset in the same cycle: reset wins.

Optional Feature:
- Macro: SP_RAM_BIST_STOP_ON_FAIL_EN.
- Defined: on the first mismatch in CMP, the run ends immediately.
  - The next state is DONE; err_cnt=1 and pass=0.
  - No further RAM accesses; ram_we stays 0.
- Undefined: the run always completes all elements, and err_cnt counts every mismatch.

Test Plan:
1. Defaults, fault-free behavioural sp_ram; pulse start.
   - busy high for exactly 240 cycles.
   - 80 ram_we pulses.
   - Then done=1, pass=1, err_cnt=0.
2. Wrapper forcing bit0 of address 5 stuck-at-0; run without the macro.
   - pass=0, err_cnt=3 (the reads of 0x55 in M1, M3 and M5).
   - fail_addr=5, fail_expect=0x55, fail_got=0x54.
3. Same fault, with SP_RAM_BIST_STOP_ON_FAIL_EN defined.
   - done rises one cycle after the M1 CMP at address 5.
   - err_cnt=1, and there is no ram_we pulse after that point.
4. Start handling:
   - Pulse start while busy → ignored; run length unchanged.
   - Pulse start after done → done clears next edge; the second run passes.
5. Reset mid-run:
   - rst_n=0 at cycle 100 → all outputs 0 at the next edge.
   - A new start then completes with pass=1.
6. READ_LATENCY=2 with a 2-stage q pipeline model.
   - Run takes 320 cycles and passes.
   - First M3 read is at address 15; last M5 read is at address 0.
